// File: rtl/uart_rx.sv
// uart_rx: 2-flop synchronised UART receiver, LSB first, one stop bit.
// Define URX_PARITY_EN to add an even-parity bit and the out_urx_pe flag.
module uart_rx #(
  parameter int DATA_W       = 6,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_urx,
  output logic [DATA_W-1:0] out_urx_data,
  output logic              out_urx_dv,
  output logic              out_urx_bs,
`ifdef URX_PARITY_EN
  output logic              out_urx_pe,
`endif
  output logic              out_urx_fe
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_MID = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_END = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef URX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic sync1, sync2, line_q;
  logic line, fall, tick;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [DATA_W-1:0] data_n;
  logic              dv_n, bs_n, fe_n;
`ifdef URX_PARITY_EN
  logic              pe_n;
`endif

  assign line = sync2;
  assign fall = line_q & ~line;
  assign tick = (cnt == CNT_END);

  // line_q holds the previous synchronised sample for edge detection
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync1  <= in_urx;
      sync2  <= sync1;
      line_q <= sync2;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      sh           <= '0;
      out_urx_data <= '0;
      out_urx_dv   <= 1'b0;
      out_urx_bs   <= 1'b0;
      out_urx_fe   <= 1'b0;
`ifdef URX_PARITY_EN
      out_urx_pe   <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      sh           <= sh_n;
      out_urx_data <= data_n;
      out_urx_dv   <= dv_n;
      out_urx_bs   <= bs_n;
      out_urx_fe   <= fe_n;
`ifdef URX_PARITY_EN
      out_urx_pe   <= pe_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    sh_n    = sh;
    data_n  = out_urx_data;
    dv_n    = 1'b0;
    bs_n    = out_urx_bs;
    fe_n    = out_urx_fe;
`ifdef URX_PARITY_EN
    pe_n    = out_urx_pe;
`endif
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (fall) begin
          state_n = START;
          bs_n    = 1'b1;
          fe_n    = 1'b0;
`ifdef URX_PARITY_EN
          pe_n    = 1'b0;
`endif
        end
      end
      START: begin
        if (cnt == CNT_MID) begin
          cnt_n = '0;
          idx_n = '0;
          if (line) begin
            state_n = IDLE;
            bs_n    = 1'b0;
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        // counter was re-zeroed mid start bit, so each wrap is mid data bit
        if (tick) begin
          cnt_n     = '0;
          sh_n[idx] = line;
          idx_n     = idx + 1'b1;
          if (idx == IDX_END) begin
`ifdef URX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef URX_PARITY_EN
      PARITY: begin
        if (tick) begin
          cnt_n   = '0;
          pe_n    = ^{sh, line};
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          cnt_n   = '0;
          state_n = IDLE;
          bs_n    = 1'b0;
          if (line) begin
            data_n = sh;
            dv_n   = 1'b1;
          end else begin
            fe_n   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
